// File: rtl/set_bit_pkg.sv
// Shared definitions for the set_bit block: op-code encoding and status bit positions.
package set_bit_pkg;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_TEST   = 2'b11
  } op_e;

  localparam int ST_W       = 4;
  localparam int ST_RANGE   = 0;
  localparam int ST_WAS_SET = 1;
  localparam int ST_ONES    = 2;
  localparam int ST_ZERO    = 3;

endpackage

// File: rtl/set_bit_decode.sv
// Converts a bit index into a one-hot mask; the mask is all zeros when the index is >= N.
module set_bit_decode #(
  parameter int N = 4
) (
  input  logic [N-1:0] idx,
  output logic [N-1:0] mask,
  output logic         in_range
);

  // one-hot decode; an out-of-range index matches no position
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == N'(i)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
  end

  assign in_range = |mask;

endmodule

// File: rtl/set_bit.sv
// Single-bit set/clear/toggle/test on an N-bit word with one-cycle registered result.
// Define SET_BIT_STATUS_EN to build the o_status flag logic; otherwise o_status is tied to 0.
module set_bit
  import set_bit_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [N-1:0]    i_argA,
  input  logic [N-1:0]    i_argB,
  output logic            o_valid,
  output logic [N-1:0]    o_result,
  output logic [ST_W-1:0] o_status
);

  logic [N-1:0]    mask_s;
  logic            in_range_s;
  logic [N-1:0]    result_s;
  logic [ST_W-1:0] status_s;

  set_bit_decode #(.N(N)) u_decode (
    .idx      (i_argB),
    .mask     (mask_s),
    .in_range (in_range_s)
  );

  // apply the op through the one-hot mask so only bit i_argB can change
  always_comb begin
    result_s = i_argA;
    if (in_range_s) begin
      case (op_e'(i_op))
        OP_SET:    result_s = i_argA | mask_s;
        OP_CLEAR:  result_s = i_argA & ~mask_s;
        OP_TOGGLE: result_s = i_argA ^ mask_s;
        OP_TEST:   result_s = i_argA;
        default:   result_s = i_argA;
      endcase
    end else begin
      result_s = i_argA;
    end
  end

`ifdef SET_BIT_STATUS_EN
  // status flags; the was-set flag reads 0 out of range because the mask is empty
  always_comb begin
    status_s             = {ST_W{1'b0}};
    status_s[ST_RANGE]   = ~in_range_s;
    status_s[ST_WAS_SET] = |(i_argA & mask_s);
    status_s[ST_ONES]    = &result_s;
    status_s[ST_ZERO]    = ~|result_s;
  end
`else
  assign status_s = {ST_W{1'b0}};
`endif

  // output register: data and status only load on a valid operation, else they hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= {N{1'b0}};
      o_status <= {ST_W{1'b0}};
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_result <= result_s;
        o_status <= status_s;
      end else begin
        o_result <= o_result;
        o_status <= o_status;
      end
    end
  end

endmodule

// File: tb/tb_set_bit.sv
// Self-checking bench for set_bit: directed table, hold/reset sequences, randomized model check.
module tb_set_bit;
  import set_bit_pkg::*;

  localparam int N = 4;
`ifdef SET_BIT_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic [1:0]   i_op;
  logic [N-1:0] i_argA;
  logic [N-1:0] i_argB;
  logic         o_valid;
  logic [N-1:0] o_result;
  logic [3:0]   o_status;

  int vectors = 0;
  int miscompares = 0;

  set_bit #(.N(N)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_status (o_status)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic [3:0]   st;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] st_exp(input logic [3:0] st);
    return STATUS_EN ? st : 4'b0000;
  endfunction

  // Reference: arithmetic on the bit weight 2**b, not mask logic
  function automatic logic [N-1:0] ref_result(input logic [1:0] op, input int a, input int b);
    int w;
    int was;
    if (b >= N) return N'(a);
    w   = 2 ** b;
    was = (a / w) % 2;
    case (op)
      2'd0:    return N'(was ? a : a + w);
      2'd1:    return N'(was ? a - w : a);
      2'd2:    return N'(was ? a - w : a + w);
      default: return N'(a);
    endcase
  endfunction

  function automatic logic [3:0] ref_status(input logic [1:0] op, input int a, input int b);
    int res;
    logic [3:0] st;
    res   = int'(ref_result(op, a, b));
    st[0] = (b >= N);
    st[1] = (b < N) && (((a / (2 ** b)) % 2) == 1);
    st[2] = (res == (2 ** N) - 1);
    st[3] = (res == 0);
    return st;
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge i_clk);
    i_valid = v;
    i_op    = op;
    i_argA  = a;
    i_argB  = b;
  endtask

  task automatic sample();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic         exp_v;
    logic [N-1:0] exp_r;
    logic [3:0]   exp_s;
    logic         v;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;

    tbl[0] = '{OP_SET,    4'b0000, 4'b0010, 4'b0100, 4'b0000};
    tbl[1] = '{OP_SET,    4'b0010, 4'b0001, 4'b0010, 4'b0010};
    tbl[2] = '{OP_SET,    4'b0000, 4'b1101, 4'b0000, 4'b1001};
    tbl[3] = '{OP_CLEAR,  4'b1111, 4'b0000, 4'b1110, 4'b0010};
    tbl[4] = '{OP_TOGGLE, 4'b0111, 4'b0011, 4'b1111, 4'b0100};
    tbl[5] = '{OP_TEST,   4'b1010, 4'b0001, 4'b1010, 4'b0010};
    tbl[6] = '{OP_TEST,   4'b1111, 4'b0100, 4'b1111, 4'b0101};
    tbl[7] = '{OP_TOGGLE, 4'b1000, 4'b0011, 4'b0000, 4'b1010};

    i_rst = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_argA = '0; i_argB = '0;
    #12;
    check("reset_valid",  32'(o_valid),  32'd0);
    check("reset_result", 32'(o_result), 32'd0);
    check("reset_status", 32'(o_status), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // directed table
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      sample();
      check($sformatf("tbl%0d_valid", i),  32'(o_valid),  32'd1);
      check($sformatf("tbl%0d_result", i), 32'(o_result), 32'(tbl[i].res));
      check($sformatf("tbl%0d_status", i), 32'(o_status), 32'(st_exp(tbl[i].st)));
    end

    // idle cycle: o_valid drops, data holds
    drive(1'b0, OP_SET, 4'b0101, 4'b0001);
    sample();
    check("hold_valid",  32'(o_valid),  32'd0);
    check("hold_result", 32'(o_result), 32'(tbl[7].res));
    check("hold_status", 32'(o_status), 32'(st_exp(tbl[7].st)));

    // async reset mid-cycle, with an op presented during reset
    drive(1'b1, OP_SET, 4'b0000, 4'b0001);
    sample();
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_valid",  32'(o_valid),  32'd0);
    check("async_rst_result", 32'(o_result), 32'd0);
    check("async_rst_status", 32'(o_status), 32'd0);
    sample();
    check("in_rst_valid", 32'(o_valid), 32'd0);
    #2;
    i_rst = 1'b0;
    drive(1'b0, OP_SET, 4'b0000, 4'b0001);
    sample();
    check("post_rst_no_stale", 32'(o_valid), 32'd0);
    sample();
    check("post_rst_no_stale2", 32'(o_valid), 32'd0);

    // op waiting at release is taken on the first edge after reset
    i_rst = 1'b1;
    drive(1'b1, OP_TOGGLE, 4'b0101, 4'b0001);
    #2;
    i_rst = 1'b0;
    sample();
    check("first_edge_valid",  32'(o_valid),  32'd1);
    check("first_edge_result", 32'(o_result), 32'h7);
    check("first_edge_status", 32'(o_status), 32'(st_exp(4'b0000)));

    // randomized back-to-back stream against the reference model
    exp_v = 1'b1;
    exp_r = 4'b0111;
    exp_s = st_exp(4'b0000);
    for (int k = 0; k < 300; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      a  = N'($urandom);
      b  = N'($urandom_range(0, 2 ** N - 1));
      drive(v, op, a, b);
      exp_v = v;
      if (v) begin
        exp_r = ref_result(op, int'(a), int'(b));
        exp_s = st_exp(ref_status(op, int'(a), int'(b)));
      end
      sample();
      check($sformatf("rnd%0d_valid", k),  32'(o_valid),  32'(exp_v));
      check($sformatf("rnd%0d_result", k), 32'(o_result), 32'(exp_r));
      check($sformatf("rnd%0d_status", k), 32'(o_status), 32'(exp_s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
